// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two valid/ready requesters.
// One operation is in flight at a time; the result returns only to the owner.

module ALU (
  output logic [31:0] result,
  output logic        zero,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  control
);

  // NOTE: the default arm assigns result on every path, so no latch is inferred.
  always_comb begin
    case (control)
      3'b000:  result = A & B;
      3'b001:  result = A | B;
      3'b010:  result = A + B;
      3'b110:  result = A - B;
      3'b111:  result = {31'b0, $signed(A) < $signed(B)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        grant0;
  logic        grant1;

  // Round-robin favours whoever was not served last; FIXED_PRIO pins ties to 0.
  assign grant0 = req0_valid & (~req1_valid | FIXED_PRIO | last_grant);
  assign grant1 = req1_valid & ~grant0;

  // Ready is gated by rst so nothing is accepted on the reset edge itself.
  assign req0_ready = (state == IDLE) & grant0 & ~rst;
  assign req1_ready = (state == IDLE) & grant1 & ~rst;
  assign busy       = (state != IDLE);

  ALU u_alu (alu_result, alu_zero, a_q, b_q, op_q);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; the reset is synchronous, hence only posedge clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            owner      <= grant1;
            last_grant <= grant1;
            a_q        <= grant1 ? req1_a  : req0_a;
            b_q        <= grant1 ? req1_b  : req0_b;
            op_q       <= grant1 ? req1_op : req0_op;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
          end
          state <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready can complete the response.
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin and a fixed-priority instance
// share one stimulus loop; a spec-level model predicts grants and responses.

module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // Index i = 2*dut + requester; dut 0 is round-robin, dut 1 is fixed priority.
  logic        req_valid  [4];
  logic        req_ready  [4];
  logic [31:0] req_a      [4];
  logic [31:0] req_b      [4];
  logic [2:0]  req_op     [4];
  logic        rsp_valid  [4];
  logic        rsp_ready  [4];
  logic [31:0] rsp_result [4];
  logic        rsp_zero   [4];
  logic        busy       [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  exp_t exp_q [4][$];
  bit   seen     [4];
  int   n_rsp    [4];
  int   grants   [4];
  bit   accepted [4];
  bit   m_idle   [2];
  int   m_last   [2];
  int   m_owner  [2];
  int   m_acc    [2];

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rsp_result[0]), .rsp0_zero(rsp_zero[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rsp_result[1]), .rsp1_zero(rsp_zero[1]),
    .busy(busy[0])
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[2]), .req0_ready(req_ready[2]),
    .req0_a(req_a[2]), .req0_b(req_b[2]), .req0_op(req_op[2]),
    .req1_valid(req_valid[3]), .req1_ready(req_ready[3]),
    .req1_a(req_a[3]), .req1_b(req_b[3]), .req1_op(req_op[3]),
    .rsp0_valid(rsp_valid[2]), .rsp0_ready(rsp_ready[2]),
    .rsp0_result(rsp_result[2]), .rsp0_zero(rsp_zero[2]),
    .rsp1_valid(rsp_valid[3]), .rsp1_ready(rsp_ready[3]),
    .rsp1_result(rsp_result[3]), .rsp1_zero(rsp_zero[3]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  function automatic exp_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input int c);
    exp_t e;
    e.res  = (op == 3'b010) ? a + b : a - b;
    e.zero = (e.res == 32'd0);
    e.cyc  = c;
    return e;
  endfunction

  function automatic void flush();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      seen[i]     = 1'b0;
      accepted[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      m_idle[d] = 1'b1;
      m_last[d] = 1;
    end
  endfunction

  // Spec-level arbitration model, evaluated at the negedge of every cycle.
  task automatic observe();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int  w;
      bit  v0;
      bit  v1;
      v0 = req_valid[2*d];
      v1 = req_valid[2*d+1];
      w  = -1;
      if (!rst && m_idle[d]) begin
        if (v0 && v1)  w = (d == 1) ? 0 : 1 - m_last[d];
        else if (v0)   w = 0;
        else if (v1)   w = 1;
      end
      check("req0_ready", d, {31'b0, req_ready[2*d]},   {31'b0, w == 0});
      check("req1_ready", d, {31'b0, req_ready[2*d+1]}, {31'b0, w == 1});
      if (!rst) check("busy", d, {31'b0, busy[d]}, {31'b0, !m_idle[d]});
      if (w >= 0) begin
        int i;
        i = 2*d + w;
        exp_q[i].push_back(alu_ref(req_a[i], req_b[i], req_op[i], cyc));
        accepted[i] = 1'b1;
        grants[i]++;
        m_idle[d]  = 1'b0;
        m_last[d]  = w;
        m_owner[d] = w;
        m_acc[d]   = cyc;
      end else if (!rst && !m_idle[d] && cyc >= m_acc[d] + 2 && rsp_ready[2*d+m_owner[d]]) begin
        m_idle[d] = 1'b1;
      end
    end
  endtask

  task automatic drive(input int p_valid, input int p_rdy, input bit fixed);
    for (int i = 0; i < 4; i++) begin
      if (!req_valid[i] || accepted[i]) begin
        accepted[i] = 1'b0;
        if ($urandom_range(99) < p_valid) begin
          req_valid[i] = 1'b1;
          if (fixed) begin
            req_a[i]  = (i % 2 == 0) ? 32'd10 : 32'd5;
            req_b[i]  = (i % 2 == 0) ? 32'd7  : 32'd5;
            req_op[i] = (i % 2 == 0) ? 3'b010 : 3'b110;
          end else begin
            req_op[i] = ($urandom_range(1) == 1) ? 3'b010 : 3'b110;
            req_a[i]  = $urandom;
            case ($urandom_range(3))
              0:       req_b[i] = req_a[i];
              1:       req_b[i] = -req_a[i];
              default: req_b[i] = $urandom;
            endcase
          end
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready[i] = ($urandom_range(99) < p_rdy);
    end
  endtask

  task automatic run(input int ncyc, input int p_valid, input int p_rdy, input bit fixed);
    repeat (ncyc) begin
      observe();
      @(posedge clk);
      #1;
      drive(p_valid, p_rdy, fixed);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_req_ready"},  i, {31'b0, req_ready[i]}, 32'd0);
      check({tag, "_rsp_valid"},  i, {31'b0, rsp_valid[i]}, 32'd0);
      check({tag, "_rsp_result"}, i, rsp_result[i],         32'd0);
      check({tag, "_rsp_zero"},   i, {31'b0, rsp_zero[i]},  32'd0);
    end
    for (int d = 0; d < 2; d++) check({tag, "_busy"}, d, {31'b0, busy[d]}, 32'd0);
  endtask

  // Response monitor: pops the scoreboard whenever a DUT presents a response.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() == 0) begin
          if (rsp_valid[i]) check("rsp_valid_unexpected", i, {31'b0, rsp_valid[i]}, 32'd0);
        end else begin
          exp_t h;
          h = exp_q[i][0];
          if (rsp_valid[i]) begin
            if (!seen[i]) check("rsp_latency", i, cyc - h.cyc, 32'd2);
            seen[i] = 1'b1;
            check("rsp_result", i, rsp_result[i], h.res);
            check("rsp_zero", i, {31'b0, rsp_zero[i]}, {31'b0, h.zero});
            check("rsp_other_valid", i, {31'b0, rsp_valid[i ^ 1]}, 32'd0);
            if (rsp_ready[i]) begin
              void'(exp_q[i].pop_front());
              seen[i] = 1'b0;
              n_rsp[i]++;
            end
          end else if (!seen[i] && cyc > h.cyc + 2) begin
            check("rsp_late", i, {31'b0, rsp_valid[i]}, 32'd1);
            seen[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int before1;
    int before3;
    for (int i = 0; i < 4; i++) begin
      n_rsp[i]     = 0;
      grants[i]    = 0;
      req_valid[i] = 1'b1;
      req_a[i]     = (i % 2 == 0) ? 32'd10 : 32'd5;
      req_b[i]     = (i % 2 == 0) ? 32'd7  : 32'd5;
      req_op[i]    = (i % 2 == 0) ? 3'b010 : 3'b110;
      rsp_ready[i] = 1'b1;
    end
    flush();
    rst = 1'b1;

    // Reset with both requesters valid: nothing may be accepted.
    repeat (2) @(posedge clk);
    observe();
    check_all_zero("reset");
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention with both held valid: RR alternates, fixed priority starves 1.
    for (int i = 0; i < 4; i++) grants[i] = 0;
    run(12, 100, 100, 1'b1);
    check("rr_grants_req0", 0, grants[0], 32'd2);
    check("rr_grants_req1", 1, grants[1], 32'd2);
    check("fp_grants_req0", 2, grants[2], 32'd4);
    check("fp_grants_req1", 3, grants[3], 32'd0);

    // Random traffic, then heavy response backpressure.
    run(400, 60, 70, 1'b0);
    run(300, 80, 20, 1'b0);
    run(30, 0, 100, 1'b0);

    // Reset during EXEC discards the operation.
    req_valid[1] = 1'b1; req_a[1] = 32'd5; req_b[1] = 32'd5; req_op[1] = 3'b110;
    req_valid[3] = 1'b1; req_a[3] = 32'd5; req_b[3] = 32'd5; req_op[3] = 3'b110;
    observe();
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b0;
    rst = 1'b1;
    flush();
    observe();
    @(posedge clk);
    #1;
    rst = 1'b0;
    observe();
    check_all_zero("midop_reset");
    @(posedge clk);
    #1;
    drive(0, 100, 1'b0);
    run(8, 0, 100, 1'b0);

    // A fresh request after the aborted one completes normally.
    before1 = n_rsp[1];
    before3 = n_rsp[3];
    req_valid[1] = 1'b1; req_a[1] = 32'd5; req_b[1] = 32'd5; req_op[1] = 3'b110;
    req_valid[3] = 1'b1; req_a[3] = 32'd5; req_b[3] = 32'd5; req_op[3] = 3'b110;
    run(10, 0, 100, 1'b0);
    check("reissue_rsp_count", 1, n_rsp[1] - before1, 32'd1);
    check("reissue_rsp_count", 3, n_rsp[3] - before3, 32'd1);

    for (int i = 0; i < 4; i++) check("scoreboard_drained", i, exp_q[i].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit `ALU` instance between two requesters, each with its own operand/op channel and response channel, using valid/ready handshakes. It arbitrates between the two requesters, registers the operands, executes on the shared ALU, and returns the registered result and zero flag to the requester that owns the operation. Only one operation is in flight at a time. The block sits between the lab control logic (or testbench drivers) and the `ALU` datapath, which it instantiates internally as `ALU(result, zero, A, B, control)`.

## Interface
- `FIXED_PRIO`, default 0. 0 = round-robin; 1 = requester 0 always wins ties.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` in 32: operands for requester 0.
- `req0_op` in 3: ALU control code for requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as the requester 0 set, for requester 1.
- `rsp0_valid` out 1: result for requester 0 available.
- `rsp0_ready` in 1: requester 0 consumes the result.
- `rsp0_result` out 32: registered ALU result for requester 0.
- `rsp0_zero` out 1: registered ALU zero flag for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`, `rsp1_zero`: same as the response 0 set, for requester 1.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - `grant0 = req0_valid & (!req1_valid | FIXED_PRIO | last_grant==1)`.
  - `grant1 = req1_valid & !grant0`.
  - `reqX_ready = IDLE & grantX` (combinational).
  - On accept: latch a, b, op and the owner ID; update `last_grant` to the owner; go to EXEC.
- **EXEC:**
  - The ALU is driven from the latched operand registers.
  - At the end of the cycle, result and zero are captured into the owner's `rsp` registers; go to RESP.
- **RESP:**
  - The owner's `rspX_valid` is high. Result and zero are held stable.
  - On `rspX_ready`: drop valid and go to IDLE.
  - The `rsp_ready` of the non-owner is ignored.
- **Handshake rules:**
  - A requester holds valid and its operands stable until ready.
  - The arbiter samples operands only in the handshake cycle.
  - Both `req_ready` are low in EXEC and RESP.
  - `rsp_ready` outside RESP has no effect.
- **Op codes:** passed to the ALU unmodified; the arbiter does not decode them. The bench uses 010 = add and 110 = subtract.
- **Arbitration:**
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - With both valid continuously under round-robin, grants alternate 0,1,0,1.
  - With FIXED_PRIO=1, requester 1 starves while requester 0 stays valid. This is accepted behaviour.
- **Reset:**
  - All outputs go to 0: `req*_ready`, `rsp*_valid`, `rsp*_result`, `rsp*_zero`, `busy`.
  - State goes to IDLE and the operand registers clear.
  - Reset during EXEC or RESP discards the operation; no response is ever produced for it.
  - `reqX_ready` is forced low while `rst` is high.

## Timing
- Request handshake at edge N. The ALU evaluates during cycle N+1. `rspX_valid` rises after edge N+1, so it is visible in cycle N+2.
- If `rsp_ready` is high in the first RESP cycle, the block is back in IDLE the following cycle. Minimum issue interval is 3 cycles.
- No combinational path from `req*_a`, `req*_b` or `req*_op` to any `rsp` output.
- `req_ready` depends combinationally on `req_valid` and state only.
- The response handshake and a new request cannot complete in the same cycle. A new accept happens no earlier than the cycle after the `rsp` handshake.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with both `req_valid`=1 → `req*_ready`=0, `rsp*_valid`=0, results 0, `busy`=0. After `rst` falls, requester 0 is granted first.
- **Single add:** req0 a=10, b=7, op=010, `rsp0_ready`=1 → `rsp0_valid` 2 cycles after the handshake with result=17, zero=0. `rsp1_valid` stays 0. `busy` is high 2 cycles.
- **Round-robin contention:** req0 (10, 7, 010) and req1 (5, 5, 110) both held valid, `rsp_ready`=1 → grant order 0,1,0,1. rsp0 result=17, zero=0; rsp1 result=0, zero=1. One accept every 3 cycles.
- **Backpressure:** `rsp0_ready`=0 for 5 cycles after `rsp0_valid` → valid and result held stable, both `req_ready` low. Raising `rsp0_ready` → valid drops and the next accept comes the following cycle.
- **Reset mid-op:** assert `rst` in the EXEC cycle → no `rsp` pulse, all outputs 0. A subsequent req1 (5, 5, 110) completes normally with result=0, zero=1.
- **FIXED_PRIO=1:** both requesters valid for 4 operations → all 4 grants go to requester 0. req1 is granted only after `req0_valid` drops.
